axi_lite_bram_slave: RTL and testbench
======================================

AXI_LITE_BRAM_SLAVE -- requirements
Module: axi_lite_bram_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 12, meaning the AXI byte-address width.
REQ-003 SHALL have parameter C_MEM_DEPTH, default 1024, meaning the number of implemented 32-bit words; C_MEM_DEPTH <= 2^(C_S_AXI_ADDR_WIDTH-2).
REQ-004 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port S_AXI_ARESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have the AXI4-Lite write channels: S_AXI_AWADDR in [ADDR_W], S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1, S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-007 SHALL have the AXI4-Lite read channels: S_AXI_ARADDR in [ADDR_W], S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-008 SHALL have the BRAM port: bram_en out 1, bram_we out 4 (byte enables), bram_addr out [ADDR_W-2] (word address), bram_wrdata out 32, bram_rddata in 32 (valid exactly 1 cycle after a bram_en read).

Function
REQ-009 SHALL be the downstream sink of the AXI-Lite DMA master, serving one transaction at a time, with no outstanding-transaction pipelining.
REQ-010 SHALL accept AW and W independently and in either order:
- AWREADY is high while no address is held and no write response is pending; the address is captured on AWVALID&&AWREADY.
- WREADY follows the same rule for data/strobe.
REQ-011 SHALL set ARREADY high while no read address is held and no read response is pending; the address is captured on handshake.
REQ-012 SHALL use the FSM states IDLE, WR, BRESP, RD, RWAIT, RRESP:
- IDLE->WR when AW and W are both held and the write is granted.
- WR->BRESP after 1 cycle.
- BRESP->IDLE on BREADY.
- IDLE->RD when AR is held and the read is granted.
- RD->RWAIT->RRESP, 1 cycle each.
- RRESP->IDLE on RREADY.
REQ-013 SHALL arbitrate round-robin when a complete write and a read are both held in IDLE. The first such conflict after reset grants the write; afterwards the grant goes to the type not granted last.
REQ-014 SHALL, in WR with an in-range address, drive bram_en=1, bram_we=WSTRB, bram_addr=AWADDR[ADDR_W-1:2] and bram_wrdata=WDATA for exactly one cycle.
REQ-015 SHALL, in RD with an in-range address, drive bram_en=1, bram_we=0 and bram_addr=ARADDR[ADDR_W-1:2]; in RWAIT it SHALL register bram_rddata into RDATA.
REQ-016 SHALL hold bram_en=0 and bram_we=0 in every other state.
REQ-017 SHALL ignore address bits [1:0]; unaligned addresses access the containing word.
REQ-018 SHALL treat a word address >= C_MEM_DEPTH as out of range:
- No BRAM access (bram_en stays 0).
- Response is SLVERR (2'b10); RDATA=0 for reads.
- All other accesses respond OKAY (2'b00).
REQ-019 SHALL keep BVALID/BRESP stable until BREADY, and RVALID/RDATA/RRESP stable until RREADY.
REQ-020 SHALL give write latency of BVALID 2 cycles after the later of the AW/W handshakes, and read latency of RVALID 3 cycles after the AR handshake, when the request is granted immediately.
REQ-021 SHALL let WSTRB=0 perform a BRAM cycle with bram_we=0 and respond OKAY.

Reset
REQ-022 SHALL, while S_AXI_ARESETN=0, force:
- state=IDLE and all held flags cleared;
- AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0;
- BRESP=RRESP=0, RDATA=0;
- bram_en=0, bram_we=0, bram_addr=0, bram_wrdata=0;
- round-robin grant set to write.
REQ-023 SHALL raise the READY outputs on the first clock edge after reset deasserts.
REQ-024 SHALL, on reset mid-transaction, abandon the transaction with no BRAM write issued after the reset assertion.

Structure
REQ-025 SHALL place the FSM state enum and the RESP_OKAY/RESP_SLVERR constants in the shared package axi_lite_bram_pkg.
REQ-026 SHALL be a single module with no sub-modules; the BRAM itself is external.

Verification
REQ-027 SHALL cover the AW-before-W case: AW 0x010, then W 0xDEADBEEF with WSTRB=0xF two cycles later -> one bram_en cycle with we=0xF, addr=4, data 0xDEADBEEF, then BRESP=OKAY.
REQ-028 SHALL cover readback: AR 0x010 -> RVALID 3 cycles after the AR handshake with RDATA=0xDEADBEEF and RRESP=OKAY.
REQ-029 SHALL cover byte strobes: W 0x11223344 with WSTRB=0x3 to 0x020 over stored 0xFFFFFFFF -> readback 0xFFFF3344.
REQ-030 SHALL cover out of range: with C_MEM_DEPTH=256, write then read at 0x400 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, bram_en never asserted.
REQ-031 SHALL cover a simultaneous conflict: write and read both held in the same cycle, twice -> write first, read second; the next conflict grants the read first.
REQ-032 SHALL cover backpressure and reset: BREADY held low for 10 cycles keeps BVALID and BRESP stable; S_AXI_ARESETN asserted in the WR state clears all outputs in the same cycle, and no further BRAM write occurs.

Source files
------------

// File: rtl/axi_lite_bram_pkg.sv
// Shared types and constants for the AXI4-Lite to BRAM bridge.
package axi_lite_bram_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR    = 3'd1,
      BRESP = 3'd2,
      RD    = 3'd3,
      RWAIT = 3'd4,
      RRESP = 3'd5
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_bram_slave.sv
// AXI4-Lite slave bridging single, non-pipelined transactions onto an external
// single-port BRAM with one-cycle read latency.
module axi_lite_bram_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 12,
   parameter int C_MEM_DEPTH        = 1024
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [31:0]                   S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [31:0]                   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic                          bram_en,
   output logic [3:0]                    bram_we,
   output logic [C_S_AXI_ADDR_WIDTH-3:0] bram_addr,
   output logic [31:0]                   bram_wrdata,
   input  logic [31:0]                   bram_rddata
);
   import axi_lite_bram_pkg::*;

   localparam int WA = C_S_AXI_ADDR_WIDTH - 2;

   state_e          state_q, state_d;
   logic            aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
   logic [WA-1:0]   aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic            rr_wr_q, rr_wr_d;
   logic            awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
   logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            bram_en_q, bram_en_d;
   logic [3:0]      bram_we_q, bram_we_d;
   logic [WA-1:0]   bram_addr_q, bram_addr_d;
   logic [31:0]     bram_wrdata_q, bram_wrdata_d;
   logic            wr_go_s, rd_go_s;
   logic            unused_s;

   assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   function automatic logic in_range(input logic [WA-1:0] word);
      return 32'(word) < 32'(C_MEM_DEPTH);
   endfunction

   // Handshake capture, arbitration, FSM next state and registered-output next values.
   always_comb begin
      state_d       = state_q;
      aw_held_d     = aw_held_q;
      aw_addr_d     = aw_addr_q;
      w_held_d      = w_held_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      ar_held_d     = ar_held_q;
      ar_addr_d     = ar_addr_q;
      rr_wr_d       = rr_wr_q;
      bvalid_d      = bvalid_q;
      bresp_d       = bresp_q;
      rvalid_d      = rvalid_q;
      rdata_d       = rdata_q;
      rresp_d       = rresp_q;
      bram_en_d     = 1'b0;
      bram_we_d     = 4'h0;
      bram_addr_d   = bram_addr_q;
      bram_wrdata_d = bram_wrdata_q;
      wr_go_s       = 1'b0;
      rd_go_s       = 1'b0;

      if (S_AXI_AWVALID && awready_q) begin
         aw_held_d = 1'b1;
         aw_addr_d = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end else begin
         aw_held_d = aw_held_q;
      end
      if (S_AXI_WVALID && wready_q) begin
         w_held_d = 1'b1;
         wdata_d  = S_AXI_WDATA;
         wstrb_d  = S_AXI_WSTRB;
      end else begin
         w_held_d = w_held_q;
      end
      if (S_AXI_ARVALID && arready_q) begin
         ar_held_d = 1'b1;
         ar_addr_d = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end else begin
         ar_held_d = ar_held_q;
      end

      case (state_q)
         IDLE: begin
            // rr_wr_q only moves on a genuine write/read conflict.
            if (aw_held_q && w_held_q && ar_held_q) begin
               wr_go_s = rr_wr_q;
               rd_go_s = !rr_wr_q;
               rr_wr_d = !rr_wr_q;
            end else begin
               wr_go_s = aw_held_q && w_held_q;
               rd_go_s = ar_held_q;
            end
            if (wr_go_s) begin
               state_d       = WR;
               aw_held_d     = 1'b0;
               w_held_d      = 1'b0;
               bram_en_d     = in_range(aw_addr_q);
               bram_we_d     = in_range(aw_addr_q) ? wstrb_q : 4'h0;
               bram_addr_d   = aw_addr_q;
               bram_wrdata_d = wdata_q;
            end else if (rd_go_s) begin
               state_d     = RD;
               ar_held_d   = 1'b0;
               bram_en_d   = in_range(ar_addr_q);
               bram_addr_d = ar_addr_q;
            end else begin
               state_d = IDLE;
            end
         end
         WR: begin
            state_d  = BRESP;
            bvalid_d = 1'b1;
            bresp_d  = in_range(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
         end
         BRESP: begin
            if (S_AXI_BREADY) begin
               state_d  = IDLE;
               bvalid_d = 1'b0;
            end else begin
               state_d = BRESP;
            end
         end
         RD: begin
            state_d = RWAIT;
         end
         RWAIT: begin
            state_d  = RRESP;
            rvalid_d = 1'b1;
            if (in_range(ar_addr_q)) begin
               rdata_d = bram_rddata;
               rresp_d = RESP_OKAY;
            end else begin
               rdata_d = 32'h0;
               rresp_d = RESP_SLVERR;
            end
         end
         RRESP: begin
            if (S_AXI_RREADY) begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
            end else begin
               state_d = RRESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      awready_d = !aw_held_d && (state_d != WR) && (state_d != BRESP);
      wready_d  = !w_held_d && (state_d != WR) && (state_d != BRESP);
      arready_d = !ar_held_d && (state_d != RD) && (state_d != RWAIT) && (state_d != RRESP);
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q       <= IDLE;
         aw_held_q     <= 1'b0;
         w_held_q      <= 1'b0;
         ar_held_q     <= 1'b0;
         aw_addr_q     <= '0;
         ar_addr_q     <= '0;
         wdata_q       <= 32'h0;
         wstrb_q       <= 4'h0;
         rr_wr_q       <= 1'b1;
         awready_q     <= 1'b0;
         wready_q      <= 1'b0;
         arready_q     <= 1'b0;
         bvalid_q      <= 1'b0;
         bresp_q       <= 2'b00;
         rvalid_q      <= 1'b0;
         rresp_q       <= 2'b00;
         rdata_q       <= 32'h0;
         bram_en_q     <= 1'b0;
         bram_we_q     <= 4'h0;
         bram_addr_q   <= '0;
         bram_wrdata_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         aw_held_q     <= aw_held_d;
         w_held_q      <= w_held_d;
         ar_held_q     <= ar_held_d;
         aw_addr_q     <= aw_addr_d;
         ar_addr_q     <= ar_addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         rr_wr_q       <= rr_wr_d;
         awready_q     <= awready_d;
         wready_q      <= wready_d;
         arready_q     <= arready_d;
         bvalid_q      <= bvalid_d;
         bresp_q       <= bresp_d;
         rvalid_q      <= rvalid_d;
         rresp_q       <= rresp_d;
         rdata_q       <= rdata_d;
         bram_en_q     <= bram_en_d;
         bram_we_q     <= bram_we_d;
         bram_addr_q   <= bram_addr_d;
         bram_wrdata_q <= bram_wrdata_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign bram_en       = bram_en_q;
   assign bram_we       = bram_we_q;
   assign bram_addr     = bram_addr_q;
   assign bram_wrdata   = bram_wrdata_q;

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// Self-checking bench: external BRAM model plus a word-array reference memory.
module tb_axi_lite_bram_slave;
   import axi_lite_bram_pkg::*;

   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst_n;
   logic [11:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [9:0]  bram_addr;
   logic [31:0] bram_wrdata, bram_rddata;

   int checks, passed;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] bmem [1024];
   logic        mem_clear;
   int          en_cnt, wr_cnt, oor_cnt;
   logic [3:0]  mon_we;
   logic [9:0]  mon_addr;
   logic [31:0] mon_data;

   axi_lite_bram_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(12), .C_MEM_DEPTH(DEPTH)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
   );

   always #5 clk = ~clk;

   // External BRAM: byte-enabled write, registered read data.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 1024; i++) bmem[i] <= 32'h0;
      end else if (bram_en) begin
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) bmem[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
         bram_rddata <= bmem[bram_addr];
      end
   end

   // BRAM activity monitor.
   always @(posedge clk) begin
      if (bram_en) begin
         en_cnt   <= en_cnt + 1;
         mon_we   <= bram_we;
         mon_addr <= bram_addr;
         mon_data <= bram_wrdata;
         if (bram_we != 4'h0) wr_cnt <= wr_cnt + 1;
         if (bram_addr >= 10'(DEPTH)) oor_cnt <= oor_cnt + 1;
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic axi_write_req(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                                input int aw_dly, input int w_dly, output int lat, output logic [1:0] resp);
      bit aw_done, w_done, aw_hs, w_hs;
      int cyc, n;
      aw_done = 1'b0; w_done = 1'b0; cyc = 0;
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && cyc < 50) begin
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done && (cyc >= w_dly);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_hs) aw_done = 1'b1;
         if (w_hs) w_done = 1'b1;
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
      lat = n; resp = bresp;
   endtask

   task automatic b_accept();
      bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
   endtask

   task automatic axi_read_req(input logic [11:0] a, input int ar_dly, output int lat,
                               output logic [1:0] resp, output logic [31:0] d);
      bit done, hs;
      int cyc, n;
      done = 1'b0; cyc = 0; araddr = a;
      while (!done && cyc < 50) begin
         arvalid = (cyc >= ar_dly);
         hs = arvalid && arready;
         @(posedge clk); #1;
         if (hs) done = 1'b1;
         cyc++;
      end
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
      lat = n; resp = rresp; d = rdata;
   endtask

   task automatic r_accept();
      rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_clear = 1'b1;
      awaddr = 12'h0; araddr = 12'h0; awprot = 3'h0; arprot = 3'h0; wdata = 32'h0; wstrb = 4'h0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({awready, wready, arready} !== 3'b000) $display("FAIL reset_ready: got %b expected 000", {awready, wready, arready}); else passed++;
      checks++; if ({bvalid, rvalid, bresp, rresp} !== 6'h0) $display("FAIL reset_resp: got %h expected 0", {bvalid, rvalid, bresp, rresp}); else passed++;
      checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else passed++;
      checks++; if ({bram_en, bram_we, bram_addr, bram_wrdata} !== 47'h0) $display("FAIL reset_bram: got %h expected 0", {bram_en, bram_we, bram_addr, bram_wrdata}); else passed++;
      mem_clear = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if ({awready, wready, arready} !== 3'b111) $display("FAIL ready_after_reset: got %b expected 111", {awready, wready, arready}); else passed++;
   endtask

   task automatic test_aw_before_w();
      int lat, e0; logic [1:0] resp;
      e0 = en_cnt;
      axi_write_req(12'h010, 32'hDEADBEEF, 4'hF, 0, 2, lat, resp);
      checks++; if (lat !== 2) $display("FAIL awfirst_latency: got %0d expected 2", lat); else passed++;
      checks++; if (en_cnt - e0 !== 1) $display("FAIL awfirst_en_cycles: got %0d expected 1", en_cnt - e0); else passed++;
      checks++; if ({mon_we, mon_addr, mon_data} !== {4'hF, 10'd4, 32'hDEADBEEF}) $display("FAIL awfirst_bram: got we=%h addr=%0d data=%h expected we=f addr=4 data=deadbeef", mon_we, mon_addr, mon_data); else passed++;
      checks++; if (resp !== RESP_OKAY) $display("FAIL awfirst_bresp: got %b expected 00", resp); else passed++;
      b_accept();
      checks++; if (bvalid !== 1'b0) $display("FAIL awfirst_bvalid_drop: got %b expected 0", bvalid); else passed++;
      ref_mem[4] = merge(ref_mem[4], 32'hDEADBEEF, 4'hF);
   endtask

   task automatic test_readback();
      int lat; logic [1:0] resp; logic [31:0] d;
      axi_read_req(12'h010, 0, lat, resp, d);
      checks++; if (lat !== 3) $display("FAIL read_latency: got %0d expected 3", lat); else passed++;
      checks++; if (d !== 32'hDEADBEEF) $display("FAIL read_data: got %h expected deadbeef", d); else passed++;
      checks++; if (resp !== RESP_OKAY) $display("FAIL read_rresp: got %b expected 00", resp); else passed++;
      r_accept();
   endtask

   task automatic test_strobes();
      int lat; logic [1:0] resp; logic [31:0] d;
      axi_write_req(12'h020, 32'hFFFFFFFF, 4'hF, 0, 0, lat, resp);
      b_accept();
      axi_write_req(12'h020, 32'h11223344, 4'h3, 3, 0, lat, resp);
      checks++; if (lat !== 2 || resp !== RESP_OKAY) $display("FAIL wfirst_write: got lat=%0d resp=%b expected lat=2 resp=00", lat, resp); else passed++;
      b_accept();
      ref_mem[8] = merge(merge(ref_mem[8], 32'hFFFFFFFF, 4'hF), 32'h11223344, 4'h3);
      axi_read_req(12'h020, 0, lat, resp, d);
      checks++; if (d !== 32'hFFFF3344) $display("FAIL strobe_readback: got %h expected ffff3344", d); else passed++;
      r_accept();
   endtask

   task automatic test_wstrb_zero();
      int lat, e0; logic [1:0] resp; logic [31:0] d;
      e0 = en_cnt;
      axi_write_req(12'h020, $urandom, 4'h0, 1, 0, lat, resp);
      checks++; if (en_cnt - e0 !== 1 || mon_we !== 4'h0) $display("FAIL strb0_bram: got cycles=%0d we=%h expected cycles=1 we=0", en_cnt - e0, mon_we); else passed++;
      checks++; if (resp !== RESP_OKAY) $display("FAIL strb0_bresp: got %b expected 00", resp); else passed++;
      b_accept();
      axi_read_req(12'h020, 0, lat, resp, d);
      checks++; if (d !== ref_mem[8]) $display("FAIL strb0_unchanged: got %h expected %h", d, ref_mem[8]); else passed++;
      r_accept();
   endtask

   task automatic test_unaligned();
      int lat; logic [1:0] resp; logic [31:0] d, wd;
      axi_read_req(12'h013, 0, lat, resp, d);
      checks++; if (d !== ref_mem[4]) $display("FAIL unaligned_read: got %h expected %h", d, ref_mem[4]); else passed++;
      r_accept();
      wd = $urandom;
      axi_write_req(12'h026, wd, 4'hF, 0, 0, lat, resp);
      checks++; if (mon_addr !== 10'd9) $display("FAIL unaligned_write_addr: got %0d expected 9", mon_addr); else passed++;
      b_accept();
      ref_mem[9] = wd;
   endtask

   task automatic test_out_of_range();
      int lat, e0; logic [1:0] resp; logic [31:0] d;
      e0 = en_cnt;
      axi_write_req(12'h400, $urandom, 4'hF, 0, 0, lat, resp);
      checks++; if (resp !== RESP_SLVERR) $display("FAIL oor_bresp: got %b expected 10", resp); else passed++;
      b_accept();
      axi_read_req(12'h400, 0, lat, resp, d);
      checks++; if (resp !== RESP_SLVERR || d !== 32'h0) $display("FAIL oor_read: got resp=%b data=%h expected resp=10 data=0", resp, d); else passed++;
      r_accept();
      checks++; if (en_cnt - e0 !== 0 || oor_cnt !== 0) $display("FAIL oor_no_bram: got en=%0d oor=%0d expected 0", en_cnt - e0, oor_cnt); else passed++;
   endtask

   task automatic test_backpressure();
      int lat; logic [1:0] resp; logic [31:0] d;
      axi_write_req(12'h7FC, $urandom, 4'hF, 0, 0, lat, resp);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++; if ({bvalid, bresp} !== 3'b110) $display("FAIL bp_bresp_stable: got %b expected 110", {bvalid, bresp}); else passed++;
      end
      b_accept();
      axi_read_req(12'h020, 0, lat, resp, d);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++; if ({rvalid, rresp, rdata} !== {1'b1, RESP_OKAY, ref_mem[8]}) $display("FAIL bp_rdata_stable: got v=%b r=%b d=%h expected d=%h", rvalid, rresp, rdata, ref_mem[8]); else passed++;
      end
      r_accept();
      checks++; if ({bvalid, rvalid} !== 2'b00) $display("FAIL bp_released: got %b expected 00", {bvalid, rvalid}); else passed++;
   endtask

   task automatic test_conflict(input bit exp_wr_first);
      int wword, rword, n, bpos, rpos;
      bit aw_d, w_d, ar_d, aw_h, w_h, ar_h;
      logic [31:0] wd, rd;
      wword = $urandom_range(0, 127); rword = $urandom_range(128, 255); wd = $urandom;
      awaddr = 12'(wword * 4); wdata = wd; wstrb = 4'hF; araddr = 12'(rword * 4);
      aw_d = 1'b0; w_d = 1'b0; ar_d = 1'b0; n = 0; rd = 32'h0;
      while (!(aw_d && w_d && ar_d) && n < 20) begin
         awvalid = !aw_d; wvalid = !w_d; arvalid = !ar_d;
         aw_h = awvalid && awready; w_h = wvalid && wready; ar_h = arvalid && arready;
         @(posedge clk); #1;
         if (aw_h) aw_d = 1'b1;
         if (w_h) w_d = 1'b1;
         if (ar_h) ar_d = 1'b1;
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b1; rready = 1'b1; bpos = -1; rpos = -1; n = 0;
      while ((bpos < 0 || rpos < 0) && n < 40) begin
         @(posedge clk); #1; n++;
         if (bvalid && bpos < 0) bpos = n;
         if (rvalid && rpos < 0) begin rpos = n; rd = rdata; end
      end
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0;
      checks++;
      if (!(bpos > 0 && rpos > 0 && ((bpos < rpos) == exp_wr_first)))
         $display("FAIL conflict_order: got bvalid@%0d rvalid@%0d expected write_first=%0d", bpos, rpos, exp_wr_first);
      else passed++;
      checks++; if (rd !== ref_mem[rword]) $display("FAIL conflict_rdata: got %h expected %h", rd, ref_mem[rword]); else passed++;
      ref_mem[wword] = wd;
   endtask

   task automatic test_random(input int count);
      int lat, word, e_lat; logic [11:0] a; logic [31:0] d, got; logic [3:0] s; logic [1:0] resp, e_resp;
      for (int i = 0; i < count; i++) begin
         word = $urandom_range(0, 299);
         a = 12'(word * 4 + $urandom_range(0, 3));
         e_resp = (word < DEPTH) ? RESP_OKAY : RESP_SLVERR;
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; s = 4'($urandom_range(0, 15)); e_lat = 2;
            axi_write_req(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), lat, resp);
            b_accept();
            if (word < DEPTH) ref_mem[word] = merge(ref_mem[word], d, s);
            checks++; if (lat !== e_lat || resp !== e_resp) $display("FAIL rand_write: addr=%h got lat=%0d resp=%b expected lat=%0d resp=%b", a, lat, resp, e_lat, e_resp); else passed++;
         end else begin
            e_lat = 3;
            axi_read_req(a, $urandom_range(0, 2), lat, resp, got);
            r_accept();
            d = (word < DEPTH) ? ref_mem[word] : 32'h0;
            checks++; if (lat !== e_lat || resp !== e_resp || got !== d) $display("FAIL rand_read: addr=%h got lat=%0d resp=%b data=%h expected lat=%0d resp=%b data=%h", a, lat, resp, got, e_lat, e_resp, d); else passed++;
         end
      end
      checks++; if (oor_cnt !== 0) $display("FAIL rand_oor_access: got %0d expected 0", oor_cnt); else passed++;
   endtask

   task automatic test_reset_mid_write();
      int word, w0; logic [31:0] m0;
      word = $urandom_range(1, 255);
      awaddr = 12'(word * 4); wdata = $urandom | 32'h1; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(posedge clk); #1;
      checks++; if (bram_en !== 1'b1) $display("FAIL midrst_in_wr: got bram_en=%b expected 1", bram_en); else passed++;
      w0 = wr_cnt; m0 = bmem[word];
      rst_n = 1'b0; #1;
      checks++; if ({bram_en, bram_we, bram_addr, bram_wrdata} !== 47'h0) $display("FAIL midrst_bram_clear: got %h expected 0", {bram_en, bram_we, bram_addr, bram_wrdata}); else passed++;
      checks++; if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'h0) $display("FAIL midrst_axi_clear: got %h expected 0", {awready, wready, arready, bvalid, rvalid, bresp, rresp}); else passed++;
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if ({awready, wready, arready} !== 3'b111) $display("FAIL midrst_ready: got %b expected 111", {awready, wready, arready}); else passed++;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (wr_cnt !== w0 || bmem[word] !== m0 || bvalid !== 1'b0) $display("FAIL midrst_no_write: got writes=%0d mem=%h bvalid=%b expected writes=%0d mem=%h bvalid=0", wr_cnt, bmem[word], bvalid, w0, m0); else passed++;
   endtask

   initial begin
      checks = 0; passed = 0;
      test_reset();
      test_aw_before_w();
      test_readback();
      test_strobes();
      test_wstrb_zero();
      test_unaligned();
      test_out_of_range();
      test_backpressure();
      test_conflict(1'b1);
      test_conflict(1'b0);
      test_conflict(1'b1);
      test_random(40);
      test_reset_mid_write();
      test_conflict(1'b1);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
